// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end for a single-ported,
// big-endian data memory. Rejects illegal accesses and extracts and extends
// the byte or half-word lane of read data on return.
//
// Handshake: a port raises p_req with all of its fields stable and keeps them
// stable until p_gnt is high in the same cycle. p_gnt completes the request,
// whether it was issued or rejected. A rejected request pulses p_err on the
// following cycle. An issued read pulses p_rvalid on the following cycle, with
// p_rdata valid only while p_rvalid is high.
module dmem_arbiter #(
  parameter int MEM_BYTES = 8096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [1:0]  p0_wscope,
  input  logic        p0_rsext,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_err,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [1:0]  p1_wscope,
  input  logic        p1_rsext,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_err,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [1:0]  mem_wscope,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] WS_BYTE = 2'b00;
  localparam logic [1:0] WS_HALF = 2'b01;
  localparam logic [1:0] WS_BAD  = 2'b10;
  localparam logic [1:0] WS_WORD = 2'b11;

  // last_gnt: 0 = port 0 was granted most recently, 1 = port 1.
  logic        last_gnt;
  logic        err0_q, err1_q;
  logic        tag_valid, tag_port, tag_rsext;
  logic [1:0]  tag_wscope, tag_off;

  logic        req0, req1, gnt0, gnt1, any_gnt, sel;
  logic        w_wr, w_rsext;
  logic [1:0]  w_wscope;
  logic [31:0] w_addr, w_wdata;
  logic [2:0]  acc_size;
  logic [32:0] end_addr;
  logic        legal, issue, reject;
  logic [31:0] ext_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Reset masks requests, so no grant is ever given while rst is high.
  assign req0    = p0_req & ~rst;
  assign req1    = p1_req & ~rst;
  assign gnt0    = req0 & (~req1 | last_gnt);
  assign gnt1    = req1 & (~req0 | ~last_gnt);
  assign any_gnt = gnt0 | gnt1;
  assign sel     = gnt1;
  assign p0_gnt  = gnt0;
  assign p1_gnt  = gnt1;

  assign w_wr     = sel ? p1_wr     : p0_wr;
  assign w_wscope = sel ? p1_wscope : p0_wscope;
  assign w_rsext  = sel ? p1_rsext  : p0_rsext;
  assign w_addr   = sel ? p1_addr   : p0_addr;
  assign w_wdata  = sel ? p1_wdata  : p0_wdata;

  // Legality of the winning request: scope, alignment and range.
  always_comb begin
    acc_size = 3'd1;
    legal    = 1'b1;
    case (w_wscope)
      WS_BYTE: acc_size = 3'd1;
      WS_HALF: begin
        acc_size = 3'd2;
        if (w_addr[0]) legal = 1'b0;
      end
      WS_WORD: begin
        acc_size = 3'd4;
        if (w_addr[1:0] != 2'b00) legal = 1'b0;
      end
      WS_BAD:  legal = 1'b0;
      default: legal = 1'b0;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    end_addr = {1'b0, w_addr} + {30'b0, acc_size};
    if (end_addr > 33'(MEM_BYTES)) legal = 1'b0;
  end

  assign issue  = any_gnt & legal;
  assign reject = any_gnt & ~legal;

  // Memory command: driven only for issued accesses, all zero otherwise.
  always_comb begin
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_wscope = 2'b00;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    if (issue) begin
      mem_en     = 1'b1;
      mem_wr     = w_wr;
      mem_wscope = w_wscope;
      mem_addr   = w_addr;
      mem_wdata  = w_wdata;
    end
  end

  // Round-robin pointer, error pulses and the read-return tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= 1'b1;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      tag_valid  <= 1'b0;
      tag_port   <= 1'b0;
      tag_wscope <= 2'b00;
      tag_off    <= 2'b00;
      tag_rsext  <= 1'b0;
    end else begin
      if (any_gnt) last_gnt <= sel;
      err0_q    <= reject & ~sel;
      err1_q    <= reject & sel;
      tag_valid <= issue & ~w_wr;
      if (issue & ~w_wr) begin
        tag_port   <= sel;
        tag_wscope <= w_wscope;
        tag_off    <= w_addr[1:0];
        tag_rsext  <= w_rsext;
      end
    end
  end

  // Response outputs are held low during reset, which also drops a read
  // that was granted in the cycle just before reset asserted.
  assign p0_err    = err0_q & ~rst;
  assign p1_err    = err1_q & ~rst;
  assign p0_rvalid = tag_valid & ~tag_port & ~rst;
  assign p1_rvalid = tag_valid & tag_port & ~rst;

  // Big-endian lane select and zero/sign extension of the returned word.
  always_comb begin
    lane_b   = 8'h0;
    lane_h   = 16'h0;
    ext_data = mem_rdata;
    case (tag_off)
      2'd0:    lane_b = mem_rdata[31:24];
      2'd1:    lane_b = mem_rdata[23:16];
      2'd2:    lane_b = mem_rdata[15:8];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = tag_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (tag_wscope)
      WS_BYTE: ext_data = {{24{tag_rsext & lane_b[7]}}, lane_b};
      WS_HALF: ext_data = {{16{tag_rsext & lane_h[15]}}, lane_h};
      default: ext_data = mem_rdata;
    endcase
  end

  assign p0_rdata = p0_rvalid ? ext_data : 32'h0;
  assign p1_rdata = p1_rvalid ? ext_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-port expected-response queue.
// Drivers push the expected read data or error marker when a grant is seen;
// a monitor pops and compares whenever a port shows p_rvalid or p_err.
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 8096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 0, p0_wr = 0, p0_rsext = 0;
  logic [1:0]  p0_wscope = 2'b11;
  logic [31:0] p0_addr = 0, p0_wdata = 0;
  logic        p1_req = 0, p1_wr = 0, p1_rsext = 0;
  logic [1:0]  p1_wscope = 2'b11;
  logic [31:0] p1_addr = 0, p1_wdata = 0;
  logic        p0_gnt, p0_err, p0_rvalid, p1_gnt, p1_err, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_wr;
  logic [1:0]  mem_wscope;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  // Expected responses: bit 32 = error pulse, bits 31:0 = p_rdata.
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:MEM_BYTES-1];

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_wscope(p0_wscope), .p0_rsext(p0_rsext),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_err(p0_err),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_wscope(p1_wscope), .p1_rsext(p1_rsext),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_err(p1_err),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_wscope(mem_wscope),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model (big-endian, 1-cycle read) ----------------
  always @(posedge clk) begin
    int a;
    a = int'(mem_addr);
    if (mem_en) begin
      if (mem_wr) begin
        case (mem_wscope)
          2'b00: if (a < MEM_BYTES) mem[a] <= mem_wdata[7:0];
          2'b01: if (a + 1 < MEM_BYTES) begin
            mem[a]   <= mem_wdata[15:8];
            mem[a+1] <= mem_wdata[7:0];
          end
          default: if (a + 3 < MEM_BYTES) begin
            mem[a]   <= mem_wdata[31:24];
            mem[a+1] <= mem_wdata[23:16];
            mem[a+2] <= mem_wdata[15:8];
            mem[a+3] <= mem_wdata[7:0];
          end
        endcase
      end else begin
        a = a & ~3;
        if (a + 3 < MEM_BYTES)
          mem_rdata <= {mem[a], mem[a+1], mem[a+2], mem[a+3]};
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation for every response a port presents.
  always @(negedge clk) begin
    logic [32:0] e;
    if (p0_rvalid || p0_err) begin
      if (exp_q0.size() == 0) check("p0_unexpected_resp", {31'b0, p0_err, p0_rdata}, 64'h0);
      else begin
        e = exp_q0.pop_front();
        check("p0_resp", {30'b0, p0_rvalid, p0_err, p0_rdata}, {30'b0, ~e[32], e});
      end
    end
    if (p1_rvalid || p1_err) begin
      if (exp_q1.size() == 0) check("p1_unexpected_resp", {31'b0, p1_err, p1_rdata}, 64'h0);
      else begin
        e = exp_q1.pop_front();
        check("p1_resp", {30'b0, p1_rvalid, p1_err, p1_rdata}, {30'b0, ~e[32], e});
      end
    end
  end

  task automatic push_exp(input int port, input logic [32:0] e);
    if (port == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  // ---------------- drivers ----------------
  task automatic set_port(input int port, input logic req, input logic wr, input logic [1:0] ws,
                          input logic sx, input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      p0_req = req; p0_wr = wr; p0_wscope = ws; p0_rsext = sx; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = req; p1_wr = wr; p1_wscope = ws; p1_rsext = sx; p1_addr = addr; p1_wdata = wd;
    end
  endtask

  // Present one request, wait (bounded) for its grant, record the expected
  // response, then release the request just after the accepting edge.
  task automatic issue(input int port, input logic wr, input logic [1:0] ws, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_data, input logic want_resp);
    logic got;
    logic g;
    got = 1'b0;
    set_port(port, 1'b1, wr, ws, sx, addr, wd);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      g = (port == 0) ? p0_gnt : p1_gnt;
      if (g) begin
        got = 1'b1;
        check("mem_en_on_grant", {63'b0, mem_en}, {63'b0, ~exp_err});
        if (!exp_err) check("mem_addr", {32'b0, mem_addr}, {32'b0, addr});
        if (exp_err) push_exp(port, {1'b1, 32'h0});
        else if (!wr && want_resp) push_exp(port, {1'b0, exp_data});
      end
    end
    if (!got) check("gnt_timeout", 64'h0, 64'h1);
    @(posedge clk);
    #1;
    set_port(port, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {p0_gnt, p1_gnt, p0_err, p1_err, p0_rvalid, p1_rvalid, mem_en, mem_wr,
                  mem_wscope, 22'b0, (p0_rdata | p1_rdata | mem_addr | mem_wdata)}, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state, with requests asserted that must be masked.
    set_port(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    set_port(0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Byte/half extraction from word 0x80A1_7F02 at 0x10.
    issue(0, 1, 2'b11, 0, 32'h10, 32'h80A1_7F02, 0, 0, 1);
    issue(0, 0, 2'b00, 1, 32'h10, 0, 0, 32'hFFFF_FF80, 1);
    issue(0, 0, 2'b00, 0, 32'h13, 0, 0, 32'h0000_0002, 1);
    issue(0, 0, 2'b01, 1, 32'h12, 0, 0, 32'h0000_7F02, 1);
    issue(0, 0, 2'b01, 0, 32'h10, 0, 0, 32'h0000_80A1, 1);
    issue(1, 0, 2'b01, 1, 32'h10, 0, 0, 32'hFFFF_80A1, 1);
    issue(1, 0, 2'b00, 0, 32'h11, 0, 0, 32'h0000_00A1, 1);
    issue(1, 0, 2'b11, 1, 32'h10, 0, 0, 32'h80A1_7F02, 1);

    // Pipelining: write then read on consecutive grants.
    issue(1, 1, 2'b11, 0, 32'h40, 32'h1234_5678, 0, 0, 1);
    issue(1, 0, 2'b11, 0, 32'h40, 0, 0, 32'h1234_5678, 1);
    // A write right after a read must not disturb that read's return.
    issue(0, 0, 2'b11, 0, 32'h40, 0, 0, 32'h1234_5678, 1);
    issue(1, 1, 2'b11, 0, 32'h40, 32'hCAFE_F00D, 0, 0, 1);
    issue(0, 0, 2'b11, 0, 32'h40, 0, 0, 32'hCAFE_F00D, 1);

    // Rejection and range boundaries.
    issue(0, 1, 2'b11, 0, 32'd8092, 32'h0BAD_F00D, 0, 0, 1);
    issue(0, 0, 2'b11, 0, 32'h22, 0, 1, 0, 1);
    issue(1, 1, 2'b00, 0, 32'd8096, 32'h0000_00EE, 1, 0, 1);
    issue(1, 0, 2'b11, 0, 32'd8092, 0, 0, 32'h0BAD_F00D, 1);
    issue(0, 0, 2'b00, 0, 32'd8095, 0, 0, 32'h0000_000D, 1);
    issue(0, 0, 2'b10, 0, 32'h10, 0, 1, 0, 1);
    issue(1, 0, 2'b01, 0, 32'h11, 0, 1, 0, 1);
    issue(1, 0, 2'b01, 0, 32'd8095, 0, 1, 0, 1);
    issue(0, 0, 2'b11, 0, 32'hFFFF_FFFC, 0, 1, 0, 1);

    // Write scopes into a zeroed word.
    issue(0, 1, 2'b11, 0, 32'h30, 32'h0, 0, 0, 1);
    issue(0, 1, 2'b00, 0, 32'h31, 32'h0000_00AB, 0, 0, 1);
    issue(1, 1, 2'b01, 0, 32'h32, 32'h0000_CDEF, 0, 0, 1);
    issue(1, 0, 2'b11, 0, 32'h30, 0, 0, 32'h00AB_CDEF, 1);

    // Contention after reset: grants alternate p0, p1, p0, p1.
    repeat (2) @(posedge clk);
    do_reset();
    set_port(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("contention_gnt", {62'b0, p1_gnt, p0_gnt}, (k % 2 == 0) ? 64'h1 : 64'h2);
      if (p0_gnt) push_exp(0, {1'b0, 32'h80A1_7F02});
      if (p1_gnt) push_exp(1, {1'b0, 32'hCAFE_F00D});
    end
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset right after a read grant: that read never returns.
    issue(1, 0, 2'b11, 0, 32'h40, 0, 0, 0, 0);
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    check_all_zero("reset_mid_read_1");
    @(negedge clk);
    check_all_zero("reset_mid_read_2");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_gnt0", {62'b0, p1_gnt, p0_gnt}, 64'h1);
    if (p0_gnt) push_exp(0, {1'b0, 32'h80A1_7F02});
    @(negedge clk);
    check("post_reset_gnt1", {62'b0, p1_gnt, p0_gnt}, 64'h2);
    if (p1_gnt) push_exp(1, {1'b0, 32'hCAFE_F00D});
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);

    // Drain and report.
    repeat (3) @(negedge clk);
    check("q0_drained", 64'(exp_q0.size()), 64'h0);
    check("q1_drained", 64'(exp_q1.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
